// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, FSM states, byte-enable generation.
package mips_mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lane 0 is bits 7:0 (little-endian).
    function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << addr_lo;
            MEM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign- or zero-extends it to 32 bits.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            MEM_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: steers loads/stores onto a req/ack bus, stalls upstream while busy,
// and aborts accesses that the bus never acknowledges.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] alu_result_out,
    output logic [31:0] memoryread,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [CNT_W-1:0] LP_CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [3:0]       r_bus_be;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_abort;

    logic        w_access;
    logic        w_fault;
    logic        w_start;
    logic        w_timeout;
    logic        w_idle;
    logic        w_req;
    logic        w_done;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;

    // A simultaneous MemRead/MemWrite is treated as a load.
    assign w_access  = MemRead | MemWrite;
    assign w_fault   = w_access & ((mem_size == 2'b11) |
                                   ((mem_size == MEM_HALF) & alu_result[0]) |
                                   ((mem_size == MEM_WORD) & (alu_result[1:0] != 2'b00)));
    assign w_idle    = (r_state == ST_IDLE);
    assign w_req     = (r_state == ST_REQ);
    assign w_done    = (r_state == ST_DONE);
    assign w_start   = w_idle & w_access & ~w_fault;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_CNT_LIMIT);

    always_comb begin
        w_wdata = write_data;
        case (mem_size)
            MEM_BYTE: w_wdata = {4{write_data[7:0]}};
            MEM_HALF: w_wdata = {2{write_data[15:0]}};
            default:  w_wdata = write_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_abort     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= MemWrite & ~MemRead;
                        r_bus_addr  <= {alu_result[31:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_be    <= gen_be(mem_size, alu_result[1:0]);
                        r_cnt       <= '0;
                        r_abort     <= 1'b0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        r_rdata   <= bus_rdata;
                        r_bus_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_abort   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    load_extend u_load_extend (
        .i_rdata    (r_rdata),
        .i_addr_lo  (alu_result[1:0]),
        .i_size     (mem_size),
        .i_unsigned (mem_unsigned),
        .o_data     (w_ext)
    );

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;

    // Inputs are frozen by stall, so DONE can reuse them for writeback and lane select.
    assign alu_result_out = alu_result;
    assign rd_out         = rd;
    assign MemToReg_out   = MemToReg;
    assign memoryread     = (w_done & MemRead & ~r_abort) ? w_ext : 32'h0;
    assign stall          = ~rst & (w_start | w_req);
    assign misaligned     = ~rst & w_idle & w_fault;
    assign bus_error      = ~rst & w_done & r_abort;
    assign RegWrite_out   = ~rst & RegWrite & ((w_idle & ~w_access) | (w_done & ~r_abort));

endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed check of mem_stage against a behavioural load/store model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  rd = '0;
    logic        RegWrite = 1'b0;
    logic        MemToReg = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] alu_result_out;
    logic [31:0] memoryread;
    logic [4:0]  rd_out;
    logic        RegWrite_out;
    logic        MemToReg_out;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_result     (alu_result),
        .write_data     (write_data),
        .rd             (rd),
        .RegWrite       (RegWrite),
        .MemToReg       (MemToReg),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .alu_result_out (alu_result_out),
        .memoryread     (memoryread),
        .rd_out         (rd_out),
        .RegWrite_out   (RegWrite_out),
        .MemToReg_out   (MemToReg_out),
        .stall          (stall),
        .misaligned     (misaligned),
        .bus_error      (bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        bus_ack  = 1'b0;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int a,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [1:0] size, input int a);
        if (size == 2'd0) return 32'(1 << a);
        if (size == 2'd1) return (a >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // One instruction through the stage; ack_dly >= 4 lets the watchdog (4 cycles) fire.
    task automatic run_op(input logic rd_en, input logic wr_en, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic regw, input int ack_dly, input logic [31:0] rdata);
        int   a;
        int   w;
        logic is_load;
        logic fault;
        logic timed_out;
        a         = int'(addr % 4);
        is_load   = rd_en;
        fault     = (rd_en | wr_en) && ((size == 2'd3) || (size == 2'd1 && (a % 2) != 0) ||
                                        (size == 2'd2 && a != 0));
        timed_out = 1'b0;
        alu_result   = addr;
        write_data   = wd;
        rd           = 5'($urandom);
        RegWrite     = regw;
        MemToReg     = rd_en;
        MemRead      = rd_en;
        MemWrite     = wr_en;
        mem_size     = size;
        mem_unsigned = uns;
        #1;
        chk("alu_result_out", alu_result_out, addr);
        chk("rd_out", 32'(rd_out), 32'(rd));
        chk("MemToReg_out", 32'(MemToReg_out), 32'(rd_en));
        if (!(rd_en | wr_en)) begin
            chk("idle stall", 32'(stall), 0);
            chk("idle RegWrite_out", 32'(RegWrite_out), 32'(regw));
            chk("idle memoryread", memoryread, 0);
            tick();
            chk("idle bus_req", 32'(bus_req), 0);
            return;
        end
        if (fault) begin
            chk("fault misaligned", 32'(misaligned), 1);
            chk("fault stall", 32'(stall), 0);
            chk("fault RegWrite_out", 32'(RegWrite_out), 0);
            tick();
            chk("fault bus_req", 32'(bus_req), 0);
            idle_inputs();
            return;
        end
        chk("start stall", 32'(stall), 1);
        chk("start RegWrite_out", 32'(RegWrite_out), 0);
        chk("start misaligned", 32'(misaligned), 0);
        for (w = 0; w < 4; w++) begin
            tick();
            bus_ack = 1'b0;
            chk("req bus_req", 32'(bus_req), 1);
            chk("req bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("req bus_we", 32'(bus_we), 32'(!is_load));
            chk("req bus_be", 32'(bus_be), ref_be(size, a));
            if (!is_load) chk("req bus_wdata", bus_wdata, ref_wdata(size, wd));
            chk("req stall", 32'(stall), 1);
            chk("req RegWrite_out", 32'(RegWrite_out), 0);
            if (w == ack_dly) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
                break;
            end
            if (w == 3) timed_out = 1'b1;
        end
        tick();
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        #1;
        chk("done bus_req", 32'(bus_req), 0);
        chk("done stall", 32'(stall), 0);
        chk("done bus_error", 32'(bus_error), 32'(timed_out));
        chk("done RegWrite_out", 32'(RegWrite_out), 32'(regw && !timed_out));
        chk("done memoryread", memoryread,
            (is_load && !timed_out) ? ref_load(rdata, a, size, uns) : 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("back idle stall", 32'(stall), 0);
        chk("back idle bus_error", 32'(bus_error), 0);
    endtask

    initial begin
        // Reset, with a faulting load presented to prove the flags stay low.
        RegWrite = 1'b1;
        MemRead  = 1'b1;
        mem_size = 2'b11;
        tick();
        tick();
        chk("rst bus_req", 32'(bus_req), 0);
        chk("rst bus_we", 32'(bus_we), 0);
        chk("rst bus_be", 32'(bus_be), 0);
        chk("rst stall", 32'(stall), 0);
        chk("rst misaligned", 32'(misaligned), 0);
        chk("rst RegWrite_out", 32'(RegWrite_out), 0);
        chk("rst bus_error", 32'(bus_error), 0);
        idle_inputs();
        rst = 1'b0;
        tick();

        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 1'b1, 0, 32'h0);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 1, 32'hDEAD_BEEF);
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 0, 32'h80FF_0000);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 2, 32'h80FF_0000);
        run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b1, 0, 32'h80FF_0000);
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h201, 32'hAB, 1'b0, 0, 32'h0);
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_5678, 1'b0, 1, 32'h0);
        run_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h104, 32'h5555_5555, 1'b1, 0, 32'h0BAD_F00D);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b1, 0, 32'h0);
        run_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 0, 32'h0);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h180, 32'h0, 1'b1, 9, 32'h0);

        // Reset while a load sits in REQ.
        alu_result = 32'h300;
        RegWrite   = 1'b1;
        MemRead    = 1'b1;
        mem_size   = 2'd2;
        tick();
        chk("rst-mid bus_req before", 32'(bus_req), 1);
        rst = 1'b1;
        #1;
        chk("rst-mid stall", 32'(stall), 0);
        chk("rst-mid RegWrite_out", 32'(RegWrite_out), 0);
        tick();
        chk("rst-mid bus_req after", 32'(bus_req), 0);
        rst = 1'b0;
        idle_inputs();
        RegWrite = 1'b1;
        #1;
        chk("rst-mid idle stall", 32'(stall), 0);
        chk("rst-mid idle RegWrite_out", 32'(RegWrite_out), 1);
        tick();
        chk("rst-mid no restart", 32'(bus_req), 0);
        idle_inputs();

        for (int i = 0; i < 60; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            run_op(kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3,
                   2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                   int'($urandom_range(0, 4)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS MEM stage between the EX/MEM register and the MEM/WB register.
- Performs byte, halfword and word loads/stores over a req/ack external data bus, with lane steering, sign/zero extension and misalignment detection.
- Asserts stall to freeze upstream stages while an access is outstanding, and drives bubbles (RegWrite_out=0) into MEM/WB, which captures every cycle unconditionally.
- A watchdog aborts accesses the bus never acknowledges.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ without bus_ack before abort; 0 disables watchdog
CNT_W, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
alu_result  in  32  effective address / ALU result from EX/MEM
write_data  in  32  store data (rt)
rd  in  5  destination register
RegWrite  in  1  writeback enable
MemToReg  in  1  writeback select
MemRead  in  1  load
MemWrite  in  1  store
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_unsigned  in  1  zero-extend load (lbu/lhu)
bus_req  out  1  access request, held until ack
bus_we  out  1  1=write
bus_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  single-cycle completion
alu_result_out  out  32  to MEM/WB
memoryread  out  32  extended load data to MEM/WB
rd_out  out  5  to MEM/WB
RegWrite_out  out  1  to MEM/WB, 0 on bubble/fault
MemToReg_out  out  1  to MEM/WB
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
misaligned  out  1  one-cycle address fault flag
bus_error  out  1  one-cycle watchdog abort flag

Behaviour:
- Registered FSM states: IDLE, REQ, DONE. Bus outputs and captured read data are registered.
- Reset:
  - state=IDLE, bus_req=0, bus_we=0, bus_be=0, counter=0, captured data=0.
  - While rst=1: stall=0, misaligned=0, bus_error=0, RegWrite_out=0.
  - Reset mid-access drops bus_req on the next edge; no completion is reported.
- Access validity:
  - access = MemRead|MemWrite.
  - If both MemRead and MemWrite are set, the access is a load and MemWrite is ignored.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0; mem_size=11 is always a fault.
- IDLE, no access:
  - Combinational pass-through: alu_result_out, rd_out, RegWrite_out, MemToReg_out follow the inputs.
  - memoryread=0, stall=0. Zero added latency.
- IDLE, access with fault:
  - No bus cycle; misaligned=1 this cycle; RegWrite_out=0; stall=0; stays IDLE.
- IDLE, valid access:
  - stall=1, RegWrite_out=0 (bubble).
  - On the edge: latch bus_addr/bus_we/bus_be/bus_wdata, set bus_req=1, clear counter, go to REQ.
- Store steering:
  - byte: wdata={4{b}}, be=1<<addr[1:0].
  - half: wdata={2{h}}, be=addr[1]?1100:0011.
  - word: be=1111.
  - Lane 0 is bits 7:0 (little-endian).
- REQ:
  - stall=1, RegWrite_out=0; bus_req and bus signals held stable.
  - bus_ack=1: capture bus_rdata, deassert bus_req, go to DONE.
  - No ack: counter+1. When counter reaches TIMEOUT_CYCLES-1 without ack: deassert bus_req, set an abort flag, go to DONE.
- DONE:
  - stall=0; outputs pass through from the inputs, which are held stable by the stall.
  - Load: memoryread = extended captured data.
    - byte: lane addr[1:0], sign-extended unless mem_unsigned.
    - half: lane addr[1], sign-extended unless mem_unsigned.
    - word: unchanged.
  - Store: memoryread=0.
  - On abort: bus_error=1, RegWrite_out=0, memoryread=0.
  - Next state IDLE unconditionally. Upstream advances on this edge, so back-to-back accesses cost 3 cycles minimum each.
- bus_ack is ignored outside REQ. An ack on the first REQ cycle is legal.
- Minimum load/store occupancy: 3 cycles (IDLE, REQ with immediate ack, DONE).

Decomposition:
- Shared package mips_mem_pkg:
  - mem_size encodings (MEM_BYTE, MEM_HALF, MEM_WORD);
  - FSM state encoding;
  - a byte-enable generation function.
- One natural sub-module: load_extend (combinational lane select plus sign/zero extension), reusable by a future cache.

Test Plan:
1. No access: alu_result=0x1234, RegWrite=1, rd=5 -> same cycle alu_result_out=0x1234, RegWrite_out=1, stall=0, bus_req never asserted.
2. lw at 0x100, ack on 2nd REQ cycle, rdata=0xDEADBEEF -> stall high 3 cycles, bubbles with RegWrite_out=0, then DONE memoryread=0xDEADBEEF, RegWrite_out=1.
3. lb at 0x103, rdata=0x80FF_0000 -> memoryread=0xFFFFFF80; lbu -> 0x00000080; lh at 0x102 -> 0xFFFF80FF.
4. sb 0xAB at 0x201 -> bus_addr=0x200, bus_we=1, bus_be=0010, bus_wdata=0xABABABAB; sh at 0x202 -> bus_be=1100.
5. lw at 0x102 -> misaligned=1 one cycle, no bus_req, RegWrite_out=0, stall=0; mem_size=11 gives the same response.
6. Watchdog and reset:
   - lw with bus_ack held 0, TIMEOUT_CYCLES=4 -> bus_req drops after 4 REQ cycles, bus_error=1 in DONE, RegWrite_out=0.
   - Separately, rst asserted in REQ -> next cycle bus_req=0, state IDLE.
